branch_redirect_ctrl: RTL and testbench

//  Sequences the fetch PC using the resolved outcome of branch_unit in EX.

---
 rtl/branch_redirect_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer: +4 per fetch handshake, redirect on taken branch/jump, fixed IF/ID flush window.
// Optional BRANCH_STATS_EN builds saturating branch/taken counters; otherwise they read as zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal sequencing; redirects, stalls and fetch_ready honoured
// ST_FLUSH | post-redirect squash window; redirects and stalls ignored
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall_in,
    input  logic        fetch_ready,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        trap_misalign,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_d;
    logic        flush_d;
    logic        trap_d;
    logic        redirect_ev;
    logic        misalign;
    logic [31:0] pc_inc;

    assign redirect_ev = ex_valid & ((ex_branch & branch_taken) | ex_jump);
    assign misalign    = |branch_target[1:0];
    assign pc_inc      = pc_out + 32'd4;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_out;
        flush_d = 1'b0;
        trap_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // a redirect wins over stall and does not wait for fetch_ready
                if (redirect_ev) begin
                    pc_d    = misalign ? TRAP_VECTOR : branch_target;
                    trap_d  = misalign;
                    flush_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT != 4'd0) ? ST_FLUSH : ST_RUN;
                end else if (!stall_in && fetch_ready) begin
                    pc_d = pc_inc;
                end
            end
            ST_FLUSH: begin
                if (fetch_ready) begin
                    pc_d = pc_inc;
                end
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= 4'd0;
            pc_out        <= RESET_PC;
            pc_valid      <= 1'b0;
            flush_if      <= 1'b0;
            flush_id      <= 1'b0;
            trap_misalign <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_out        <= pc_d;
            pc_valid      <= 1'b1;
            flush_if      <= flush_d;
            flush_id      <= flush_d;
            trap_misalign <= trap_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic count_br;

    assign count_br = (state_q == ST_RUN) & ex_valid & ex_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= 32'd0;
            stat_taken    <= 32'd0;
        end else if (count_br) begin
            if (stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (branch_taken && stat_taken != 32'hFFFF_FFFF) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`else
    assign stat_branches = 32'd0;
    assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios then random traffic vs a cycle-level reference model.
module tb_branch_redirect_ctrl;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_branch, ex_jump, branch_taken, stall_in, fetch_ready;
    logic [31:0] branch_target;
    logic [31:0] pc_out, stat_branches, stat_taken;
    logic        pc_valid, flush_if, flush_id, trap_misalign;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_valid, m_trap;
    int          m_flush_left;
    logic [31:0] m_br, m_tk;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(
        .RESET_PC    (RESET_PC),
        .TRAP_VECTOR (TRAP_VECTOR),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall_in     (stall_in),
        .fetch_ready  (fetch_ready),
        .pc_out       (pc_out),
        .pc_valid     (pc_valid),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .trap_misalign(trap_misalign),
        .stat_branches(stat_branches),
        .stat_taken   (stat_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
        end
    endtask

    // One clock of the spec's behaviour, applied to the inputs sampled at the edge.
    task automatic model_step();
        logic accepting;
        logic redir;
        if (rst) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_trap = 1'b0;
            m_flush_left = 0; m_br = 0; m_tk = 0;
            return;
        end
        m_valid   = 1'b1;
        m_trap    = 1'b0;
        // a one-cycle window returns to normal sequencing immediately
        accepting = (m_flush_left == 0) || (FLUSH_CYCLES == 1);
        if (accepting) begin
            if (ex_valid && ex_branch) begin
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (branch_taken && m_tk != 32'hFFFF_FFFF) m_tk = m_tk + 1;
            end
            redir = ex_valid && ((ex_branch && branch_taken) || ex_jump);
            if (redir) begin
                if (branch_target % 4 != 0) begin
                    m_pc   = TRAP_VECTOR;
                    m_trap = 1'b1;
                end else begin
                    m_pc = branch_target;
                end
                m_flush_left = FLUSH_CYCLES;
            end else begin
                if (!stall_in && fetch_ready) m_pc = m_pc + 4;
                if (m_flush_left > 0) m_flush_left--;
            end
        end else begin
            if (fetch_ready) m_pc = m_pc + 4;
            m_flush_left--;
        end
    endtask

    task automatic check_all();
        logic m_flush;
        m_flush = (m_flush_left > 0);
        chk("pc_out", pc_out, m_pc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        chk("flush_if", {31'd0, flush_if}, {31'd0, m_flush});
        chk("flush_id", {31'd0, flush_id}, {31'd0, m_flush});
        chk("trap_misalign", {31'd0, trap_misalign}, {31'd0, m_trap});
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, m_br);
        chk("stat_taken", stat_taken, m_tk);
`else
        chk("stat_branches", stat_branches, 32'd0);
        chk("stat_taken", stat_taken, 32'd0);
`endif
    endtask

    task automatic cyc(input logic r, input logic v, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic st, input logic rdy);
        rst = r; ex_valid = v; ex_branch = br; ex_jump = jmp;
        branch_taken = tk; branch_target = tgt; stall_in = st; fetch_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] tgt;
        // reset for two cycles, then free-running fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'd0, pc_valid}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("seq_pc", pc_out, 32'h14);

        // taken branch to 0x40 while pc is 0x14
        cyc(0, 1, 1, 0, 1, 32'h40, 0, 1);
        chk("redir_pc", pc_out, 32'h40);
        cyc(0, 1, 1, 0, 1, 32'h200, 1, 1);   // ignored inside the flush window
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_flush", {31'd0, flush_if}, 32'd0);

        // not-taken branch, stall, stall+jump, misaligned target
        cyc(0, 1, 1, 0, 0, 32'h300, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 1, 0, 32'h80, 1, 0);
        chk("jump_pc", pc_out, 32'h80);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 1, 32'h42, 0, 1);
        chk("trap_pc", pc_out, TRAP_VECTOR);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);          // reset aborts the window

        // pc wrap at the top of the address space
        cyc(0, 1, 0, 1, 0, 32'hFFFF_FFF8, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(15) == 0) tgt = 32'hFFFF_FFF0;
            cyc($urandom_range(63) == 0,
                $urandom_range(1), $urandom_range(1),
                $urandom_range(7) == 0, $urandom_range(1), tgt,
                $urandom_range(3) == 0, $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
